regfile_ctrl: RTL
=================

REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 Parameter DATA_W, 8, register data width.
REQ-002 Parameter ADDR_W, 3, register address width (8 registers).
REQ-003 One clock; reset is synchronous and active-high. Ports: clk, rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 dec_valid  input  1  decoded instruction present.
REQ-007 dec_ready  output  1  instruction accepted this cycle.
REQ-008 dec_rs1, dec_rs2  input  ADDR_W each  source register addresses.
REQ-009 dec_rd  input  ADDR_W  destination register address.
REQ-010 dec_we  input  1  instruction writes dec_rd.
REQ-011 rf_rs1, rf_rs2  output  ADDR_W each  register-file read addresses; the register file returns data combinationally.
REQ-012 rf_rdata1, rf_rdata2  input  DATA_W each  register-file read data.
REQ-013 rf_we, rf_wa, rf_wd  output  1/ADDR_W/DATA_W  register-file write port; the register file writes on the clk edge.
REQ-014 wb_valid, wb_rd, wb_data  input  1/ADDR_W/DATA_W  ALU write-back result.
REQ-015 op_valid  output  1  operand bundle valid.
REQ-016 op_ready  input  1  execute stage consumes the bundle.
REQ-017 op_a, op_b, op_rd, op_we  output  DATA_W/DATA_W/ADDR_W/1  registered operand bundle.

Function
REQ-018 rf_rs1 SHALL equal dec_rs1 and rf_rs2 SHALL equal dec_rs2 combinationally.
REQ-019 rf_we SHALL equal wb_valid AND NOT rst; rf_wa SHALL equal wb_rd; rf_wd SHALL equal wb_data, all combinational.
REQ-020 The block SHALL hold an 8-bit pending vector, one bit per register, marking in-flight writes.
REQ-021 Hazard SHALL be true when pending[dec_rs1], pending[dec_rs2], or (dec_we and pending[dec_rd]) is set and that register is not matched by wb_valid and wb_rd in the same cycle.
REQ-022 dec_ready SHALL equal (NOT op_valid OR op_ready) AND NOT hazard AND NOT rst.
REQ-023 On accept (dec_valid and dec_ready) at edge N, op_valid SHALL be 1 after edge N, with op_rd = dec_rd and op_we = dec_we; latency is 1 cycle.
REQ-024 op_a SHALL capture wb_data if wb_valid and wb_rd == dec_rs1, else rf_rdata1; op_b is the same with dec_rs2 and rf_rdata2.
REQ-025 The output buffer has 2 states, EMPTY and FULL. EMPTY goes to FULL on accept. FULL goes to EMPTY on op_ready with no accept. FULL stays FULL with a new bundle on op_ready with accept. FULL holds when op_ready is 0.
REQ-026 While op_valid is 1 and op_ready is 0, op_a, op_b, op_rd and op_we SHALL remain stable.
REQ-027 pending[wb_rd] SHALL clear on wb_valid. pending[dec_rd] SHALL set on accept with dec_we. If both hit the same register in one cycle, set SHALL win.
REQ-028 wb_valid with a non-pending wb_rd SHALL still write the register file and SHALL leave pending unchanged.
REQ-029 An instruction with dec_rs1 == dec_rs2 SHALL be handled normally, and both operands SHALL receive identical data.

Reset
REQ-030 At the first edge with rst = 1, op_valid, op_we and pending SHALL go to 0, and op_a, op_b and op_rd SHALL go to 0.
REQ-031 A reset mid-operation SHALL discard the buffered bundle and all pending bits.
REQ-032 While rst is 1, dec_ready and rf_we SHALL be 0.

Structure
REQ-033 DATA_W, ADDR_W and NUM_REGS = 8 SHALL live in the shared package regfile_pkg.
REQ-034 The pending vector and hazard logic SHALL be the single sub-module reg_scoreboard.

Verification
REQ-035 Write-back r0 = 0xAA, then r7 = 0xF0; then decode rs1 = 0, rs2 = 7 -> op_a = 0xAA, op_b = 0xF0, op_valid 1 cycle after accept.
REQ-036 Decode with dec_we, rd = 3; then decode rs1 = 3 -> dec_ready = 0 until wb_valid with wb_rd = 3 and wb_data = 0x5C. In that cycle the instruction is accepted and op_a = 0x5C via forwarding.
REQ-037 op_ready held 0 for 4 cycles with dec_valid = 1 -> dec_ready = 0 and the bundle is stable. When op_ready = 1, back-to-back acceptance resumes at 1 per cycle.
REQ-038 Same-cycle wb_valid on rd = 2 and accept with dec_we, rd = 2 -> pending[2] = 1 afterwards.
REQ-039 Assert rst while op_valid = 1 and pending = 0x88 -> after the edge, op_valid = 0, pending = 0 and all outputs = 0.
REQ-040 Decode rs1 = rs2 = 5 with r5 = 0x3C -> op_a = op_b = 0x3C.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, buffer state encoding and operand bundle layout for regfile_ctrl.
package regfile_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 8;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [ADDR_W-1:0] rd;
        logic              we;
    } op_bundle_t;

endpackage

// File: rtl/regfile_ctrl_if.sv
// Decode, register-file, write-back and operand-bundle signals of regfile_ctrl.
interface regfile_ctrl_if;
    import regfile_pkg::*;

    logic              dec_valid;
    logic              dec_ready;
    logic [ADDR_W-1:0] dec_rs1;
    logic [ADDR_W-1:0] dec_rs2;
    logic [ADDR_W-1:0] dec_rd;
    logic              dec_we;

    logic [ADDR_W-1:0] rf_rs1;
    logic [ADDR_W-1:0] rf_rs2;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ADDR_W-1:0] op_rd;
    logic              op_we;

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_we,
        input  rf_rdata1, rf_rdata2,
        input  wb_valid, wb_rd, wb_data,
        input  op_ready,
        output dec_ready, rf_rs1, rf_rs2, rf_we, rf_wa, rf_wd,
        output op_valid, op_a, op_b, op_rd, op_we
    );

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_we,
        output rf_rdata1, rf_rdata2,
        output wb_valid, wb_rd, wb_data,
        output op_ready,
        input  dec_ready, rf_rs1, rf_rs2, rf_we, rf_wa, rf_wd,
        input  op_valid, op_a, op_b, op_rd, op_we
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, plus the read/write hazard check.
module reg_scoreboard
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_rs1,
    input  logic [ADDR_W-1:0] i_rs2,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic              i_rd_we,
    input  logic              i_set,
    input  logic              i_wb_valid,
    input  logic [ADDR_W-1:0] i_wb_rd,
    output logic              o_hazard_c
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_wb_hit;
    logic [NUM_REGS-1:0] w_set_vec;
    logic [NUM_REGS-1:0] w_live;

    always_comb begin
        w_wb_hit           = '0;
        w_set_vec          = '0;
        w_wb_hit[i_wb_rd]  = i_wb_valid;
        w_set_vec[i_rd]    = i_set;
    end

    // A write-back landing this cycle resolves the hazard on its register.
    assign w_live     = r_pending & ~w_wb_hit;
    assign o_hazard_c = w_live[i_rs1] | w_live[i_rs2] | (i_rd_we & w_live[i_rd]);

    // Set is applied after clear so a same-register collision stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_wb_hit) | w_set_vec;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Operand-fetch stage: reads sources, forwards write-back data, tracks pending
// destinations and holds a one-entry operand bundle for the execute stage.
module regfile_ctrl
    import regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    regfile_ctrl_if.slave bus
);

    buf_state_e r_state;
    buf_state_e w_state_nxt;
    op_bundle_t r_op;
    op_bundle_t w_op_nxt;
    logic       w_hazard;
    logic       w_dec_ready;
    logic       w_accept;
    logic       w_load;

    assign bus.rf_rs1 = bus.dec_rs1;
    assign bus.rf_rs2 = bus.dec_rs2;
    assign bus.rf_we  = bus.wb_valid & ~rst;
    assign bus.rf_wa  = bus.wb_rd;
    assign bus.rf_wd  = bus.wb_data;

    reg_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_rs1      (bus.dec_rs1),
        .i_rs2      (bus.dec_rs2),
        .i_rd       (bus.dec_rd),
        .i_rd_we    (bus.dec_we),
        .i_set      (w_accept & bus.dec_we),
        .i_wb_valid (bus.wb_valid),
        .i_wb_rd    (bus.wb_rd),
        .o_hazard_c (w_hazard)
    );

    assign w_dec_ready   = ((r_state == BUF_EMPTY) | bus.op_ready) & ~w_hazard & ~rst;
    assign w_accept      = bus.dec_valid & w_dec_ready;
    assign bus.dec_ready = w_dec_ready;

    // Operands bypass the register file when write-back targets the same register.
    always_comb begin
        w_op_nxt.a  = (bus.wb_valid && bus.wb_rd == bus.dec_rs1) ? bus.wb_data : bus.rf_rdata1;
        w_op_nxt.b  = (bus.wb_valid && bus.wb_rd == bus.dec_rs2) ? bus.wb_data : bus.rf_rdata2;
        w_op_nxt.rd = bus.dec_rd;
        w_op_nxt.we = bus.dec_we;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        unique case (r_state)
            BUF_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = BUF_FULL;
                    w_load      = 1'b1;
                end
            end
            BUF_FULL: begin
                if (w_accept) begin
                    w_load = 1'b1;
                end else if (bus.op_ready) begin
                    w_state_nxt = BUF_EMPTY;
                end
            end
            default: w_state_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= '0;
        end else if (w_load) begin
            r_op <= w_op_nxt;
        end
    end

    assign bus.op_valid = (r_state == BUF_FULL);
    assign bus.op_a     = r_op.a;
    assign bus.op_b     = r_op.b;
    assign bus.op_rd    = r_op.rd;
    assign bus.op_we    = r_op.we;

endmodule
